mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 52 +++++
 rtl/mem_access_unit_load_ext.sv | 41 ++++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: op encodings, FSM states,
// bus size codes and op-classification helpers.
package mem_access_unit_pkg;

    localparam int ALUOP_W = 8;
    typedef logic [ALUOP_W-1:0] alu_op_t;

    localparam alu_op_t EXE_NOP_OP = 8'b0000_0000;
    localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
    localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
    localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
    localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
    localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
    localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
    localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
    localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } mau_state_t;

    function automatic logic op_is_load(input alu_op_t op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: op_is_load = 1'b1;
            default:                                                 op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input alu_op_t op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: op_is_store = 1'b1;
            default:                         op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input alu_op_t op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SIZE_HALF;
            default:                          op_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Little-endian load lane selection with sign/zero extension; purely combinational.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lanes, then extend according to the op.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
        case (op)
            EXE_LB_OP:  load_data = {{24{byte_s[7]}}, byte_s};
            EXE_LBU_OP: load_data = {24'h00_0000, byte_s};
            EXE_LH_OP:  load_data = {{16{half_s[15]}}, half_s};
            EXE_LHU_OP: load_data = {16'h0000, half_s};
            EXE_LW_OP:  load_data = raw;
            default:    load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data bus master: alignment checks, request handshake, flush draining
// and aligned load return for a simple request/response data bus.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_except_type,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] load_data,
    output logic        stallreq,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr
);

    mau_state_t  state_r, state_nxt_s;
    logic        is_load_s, is_store_s, is_mem_s;
    logic        misalign_s, issuable_s, capture_s;
    logic [31:0] ext_data_s, load_data_r;

    assign is_load_s  = op_is_load(mem_aluop);
    assign is_store_s = op_is_store(mem_aluop);
    assign is_mem_s   = is_load_s | is_store_s;
    assign issuable_s = is_mem_s & ~misalign_s & (mem_except_type == 32'h0000_0000) & ~flush;

    // Alignment check per access width.
    always_comb begin
        misalign_s = 1'b0;
        case (mem_aluop)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign_s = mem_mem_addr[0];
            EXE_LW_OP, EXE_SW_OP:             misalign_s = |mem_mem_addr[1:0];
            default:                          misalign_s = 1'b0;
        endcase
    end

    assign adel      = is_load_s & misalign_s;
    assign ades      = is_store_s & misalign_s;
    assign bad_vaddr = (adel | ades) ? mem_mem_addr : 32'h0000_0000;

    // Store data replicated across byte lanes so the bus can use any lane.
    always_comb begin
        data_wdata = mem_reg2;
        case (mem_aluop)
            EXE_SB_OP: data_wdata = {4{mem_reg2[7:0]}};
            EXE_SH_OP: data_wdata = {2{mem_reg2[15:0]}};
            default:   data_wdata = mem_reg2;
        endcase
    end

    // Request fields pass straight through; the stall keeps them stable.
    assign data_wr   = is_store_s;
    assign data_size = op_size(mem_aluop);
    assign data_addr = mem_mem_addr;

    mem_load_ext u_load_ext (
        .op        (mem_aluop),
        .addr_lo   (mem_mem_addr[1:0]),
        .raw       (data_rdata),
        .load_data (ext_data_s)
    );

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        data_req    = 1'b0;
        stallreq    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (issuable_s) begin
                    data_req = 1'b1;
                    stallreq = 1'b1;
                    if (data_addr_ok) begin
                        state_nxt_s = WAIT;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                // data_data_ok is never accepted here: the response must follow addr_ok.
                data_req = 1'b1;
                stallreq = issuable_s;
                if (flush) begin
                    state_nxt_s = data_addr_ok ? DRAIN : IDLE;
                end else if (data_addr_ok) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                stallreq = issuable_s;
                if (flush) begin
                    state_nxt_s = data_data_ok ? IDLE : DRAIN;
                end else if (data_data_ok) begin
                    capture_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            DRAIN: begin
                // A stale response is outstanding; hold any new memory op back.
                stallreq = is_mem_s;
                if (data_data_ok) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and captured load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            load_data_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                load_data_r <= ext_data_s;
            end else begin
                load_data_r <= load_data_r;
            end
        end
    end

    assign load_data = load_data_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk, rst, flush;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr, mem_reg2, mem_except_type;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, load_data;
    logic        stallreq, adel, ades;
    logic [31:0] bad_vaddr;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cnt;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_except_type(mem_except_type),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .load_data(load_data), .stallreq(stallreq),
        .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        mem_aluop       = EXE_NOP_OP;
        mem_mem_addr    = 32'h0000_0000;
        mem_reg2        = 32'h0000_0000;
        mem_except_type = 32'h0000_0000;
        flush           = 1'b0;
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;
        data_rdata      = 32'h0000_0000;
    endtask

    // Load accepted immediately, response one cycle later, result checked in DONE.
    task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        mem_aluop    = op;
        mem_mem_addr = addr;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_stall"}, {31'd0, stallreq}, 32'd0);
        tick();
        idle_bus();
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_load", load_data, 32'h0000_0000);
        tick();

        // LW, addr_ok same cycle, data_ok two cycles later
        stall_cnt    = 0;
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h8000_0004;
        data_addr_ok = 1'b1;
        @(negedge clk);
        chk("lw_req", {31'd0, data_req}, 32'd1);
        chk("lw_size", {30'd0, data_size}, 32'd2);
        chk("lw_wr", {31'd0, data_wr}, 32'd0);
        chk("lw_addr", data_addr, 32'h8000_0004);
        stall_cnt += int'(stallreq);
        tick();
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("lw_req_drop", {31'd0, data_req}, 32'd0);
        stall_cnt += int'(stallreq);
        tick();
        data_data_ok = 1'b1;
        data_rdata   = 32'h1234_5678;
        @(negedge clk);
        stall_cnt += int'(stallreq);
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        stall_cnt += int'(stallreq);
        chk("lw_done_data", load_data, 32'h1234_5678);
        chk("lw_stall_cycles", stall_cnt, 32'd3);
        tick();
        idle_bus();

        do_load("lb", EXE_LB_OP, 32'h8000_0003, 32'h80FF_FFFF, 32'hFFFF_FF80);
        do_load("lbu", EXE_LBU_OP, 32'h8000_0003, 32'h80FF_FFFF, 32'h0000_0080);
        do_load("lh", EXE_LH_OP, 32'h0000_0002, 32'h80FF_FFFF, 32'hFFFF_80FF);
        do_load("lhu", EXE_LHU_OP, 32'h0000_0000, 32'h1234_F00D, 32'h0000_F00D);
        do_load("lb1", EXE_LB_OP, 32'h0000_0001, 32'h0000_7F00, 32'h0000_007F);

        // Reset mid-transaction while in REQ
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h0000_0040;
        tick();
        @(negedge clk);
        chk("rstreq_req_held", {31'd0, data_req}, 32'd1);
        rst = 1'b1;
        mem_aluop = EXE_NOP_OP;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_state", 32'(dut.state_r), 32'(IDLE));
        chk("rstreq_req", {31'd0, data_req}, 32'd0);
        chk("rstreq_stall", {31'd0, stallreq}, 32'd0);
        chk("rstreq_load", load_data, 32'h0000_0000);
        tick();
        idle_bus();

        // SH with addr_ok delayed three cycles; spurious data_ok in REQ is ignored
        mem_aluop    = EXE_SH_OP;
        mem_mem_addr = 32'h0000_0002;
        mem_reg2     = 32'hAAAA_1234;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            data_data_ok = (i == 1);
            @(negedge clk);
            chk($sformatf("sh_req%0d", i), {31'd0, data_req}, 32'd1);
            chk($sformatf("sh_wdata%0d", i), data_wdata, 32'h1234_1234);
            chk($sformatf("sh_size%0d", i), {30'd0, data_size}, 32'd1);
            chk($sformatf("sh_wr%0d", i), {31'd0, data_wr}, 32'd1);
            chk($sformatf("sh_addr%0d", i), data_addr, 32'h0000_0002);
            chk($sformatf("sh_stall%0d", i), {31'd0, stallreq}, 32'd1);
            tick();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        @(negedge clk);
        chk("sh_wait_req", {31'd0, data_req}, 32'd0);
        chk("sh_wait_stall", {31'd0, stallreq}, 32'd1);
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("sh_done_stall", {31'd0, stallreq}, 32'd0);
        tick();
        idle_bus();

        // Upstream exception suppresses access; lane replication still visible
        mem_aluop       = EXE_SB_OP;
        mem_reg2        = 32'h0000_00A5;
        mem_except_type = 32'h0000_0100;
        @(negedge clk);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        chk("exc_req", {31'd0, data_req}, 32'd0);
        chk("exc_stall", {31'd0, stallreq}, 32'd0);
        tick();
        idle_bus();

        // Misaligned accesses
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h0000_0006;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lwmis_adel", {31'd0, adel}, 32'd1);
            chk("lwmis_ades", {31'd0, ades}, 32'd0);
            chk("lwmis_badv", bad_vaddr, 32'h0000_0006);
            chk("lwmis_req", {31'd0, data_req}, 32'd0);
            chk("lwmis_stall", {31'd0, stallreq}, 32'd0);
            tick();
        end
        mem_aluop    = EXE_SH_OP;
        mem_mem_addr = 32'h0000_0003;
        @(negedge clk);
        chk("shmis_ades", {31'd0, ades}, 32'd1);
        chk("shmis_badv", bad_vaddr, 32'h0000_0003);
        chk("shmis_req", {31'd0, data_req}, 32'd0);
        tick();
        mem_aluop    = EXE_SW_OP;
        mem_mem_addr = 32'h0000_0104;
        mem_except_type = 32'h0000_0001;
        @(negedge clk);
        chk("swok_ades", {31'd0, ades}, 32'd0);
        chk("swok_badv", bad_vaddr, 32'h0000_0000);
        tick();
        idle_bus();

        // Flush in WAIT, new SW must wait for the stale response
        mem_aluop    = EXE_LW_OP;
        mem_mem_addr = 32'h0000_0100;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
        mem_aluop    = EXE_SW_OP;
        mem_mem_addr = 32'h0000_0200;
        mem_reg2     = 32'h1122_3344;
        for (int i = 0; i < 3; i++) begin
            data_data_ok = (i == 2);
            @(negedge clk);
            chk($sformatf("drain_stall%0d", i), {31'd0, stallreq}, 32'd1);
            chk($sformatf("drain_req%0d", i), {31'd0, data_req}, 32'd0);
            tick();
        end
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("sw_issue_req", {31'd0, data_req}, 32'd1);
        chk("sw_issue_wr", {31'd0, data_wr}, 32'd1);
        chk("sw_issue_wdata", data_wdata, 32'h1122_3344);
        chk("sw_issue_stall", {31'd0, stallreq}, 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        @(negedge clk);
        chk("sw_done_stall", {31'd0, stallreq}, 32'd0);
        tick();
        idle_bus();
        @(negedge clk);
        chk("final_idle_req", {31'd0, data_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
